uparc_ifu_bus: RTL and testbench
================================

Name: uparc_ifu_bus

Overview:
- Instruction fetch unit directly upstream of the fetch pipeline stage.
- Accepts one read command per cycle from fetch (i_addr, i_rd_cmd) and runs a single-outstanding word read on the instruction bus.
- Holds o_busy as a stall while the read is in flight, then holds returned instruction data stable until the next command.
- Reports alignment, bus and timeout errors as one-cycle pulses.

Parameters:
ADDR_WIDTH, 32, address width.
DATA_WIDTH, 32, instruction/bus data width.
BUS_TIMEOUT, 255, max cycles in WAIT before forced bus error; 0 disables the timeout.

Ports:
clk  input  1  clock
nrst  input  1  asynchronous active-low reset
i_addr  input  ADDR_WIDTH  fetch address, sampled with i_rd_cmd
i_rd_cmd  input  1  one-cycle read command from fetch
o_instr_dat  output  DATA_WIDTH  fetched instruction, held until next command
o_busy  output  1  read in progress; fetch stalls while high
o_err_align  output  1  one-cycle pulse: i_addr[1:0]!=0
o_err_bus  output  1  one-cycle pulse: bus error or timeout
i_flush  input  1  invalidate hit buffer (used only with optional feature)
o_bus_addr  output  ADDR_WIDTH  bus read address
o_bus_cmd  output  1  bus read request, held until accepted
i_bus_rdy  input  1  bus accepts request at clock edge when o_bus_cmd=1
i_bus_data  input  DATA_WIDTH  read data
i_bus_dvalid  input  1  read data valid
i_bus_err  input  1  read terminated with error

Behaviour:
- Reset values: state IDLE, o_instr_dat=0, o_bus_addr=0, o_bus_cmd=0, o_err_align=0, o_err_bus=0, timeout counter=0.
- Reset mid-transaction aborts immediately. Stray i_bus_dvalid/i_bus_err seen in IDLE are ignored.
- IDLE:
  - i_rd_cmd with i_addr[1:0]==0: latch o_bus_addr=i_addr, o_bus_cmd<=1, go to REQ.
  - i_rd_cmd with i_addr[1:0]!=0: no bus access, o_instr_dat<=0, o_err_align<=1 for one cycle, stay IDLE.
- REQ: o_bus_cmd=1 and o_bus_addr stable. On edge with i_bus_rdy=1: o_bus_cmd<=0, clear counter, go to WAIT.
- WAIT:
  - i_bus_dvalid=1: o_instr_dat<=i_bus_data, go to IDLE.
  - Otherwise i_bus_err=1: o_instr_dat<=0, o_err_bus<=1 for one cycle, go to IDLE.
  - dvalid and err together: err wins; data discarded, o_instr_dat=0.
  - i_bus_dvalid/i_bus_err are ignored in REQ; the bus never returns data on its accept cycle.
- Timeout (BUS_TIMEOUT>0): the counter increments each WAIT cycle with no response. When it reaches BUS_TIMEOUT, behave as i_bus_err. The counter saturates and never wraps.
- o_busy is combinational: (i_rd_cmd && i_addr[1:0]==0 && !hit) || state!=IDLE. It rises in the command cycle, so fetch stalls the same cycle.
- o_busy falls in the cycle after response; o_instr_dat is valid from that cycle.
- Min latency (rdy in first REQ cycle, dvalid next): command at N, o_bus_cmd N+1, dvalid N+2, o_busy low and data valid N+3.
- i_rd_cmd while state!=IDLE is ignored; fetch never issues while stalled.
- o_instr_dat is unchanged between commands.

Optional Feature:
- Macro UPARC_IFU_HIT_BUF_EN.
- With the macro: one-entry buffer of {valid, addr, data}.
  - Filled on successful dvalid completion.
  - Cleared on reset, on bus error/timeout, and on i_flush (i_flush has priority over a same-cycle fill).
  - i_rd_cmd to an aligned address equal to the buffered address while valid is a hit: o_instr_dat<=buffered data next cycle, o_busy stays 0, no bus request.
- Without the macro: the buffer is not built, hit=0, and i_flush is ignored.

Test Plan:
- Reset, then i_rd_cmd with i_addr=0x100; bus: rdy at first REQ cycle, dvalid next cycle with data 0x24020005 -> o_bus_cmd high 1 cycle with o_bus_addr=0x100; o_busy high cycles N..N+2; o_instr_dat=0x24020005 from N+3.
- i_rd_cmd with i_addr=0x102 -> o_err_align=1 at N+1 only, o_busy=0 throughout, o_bus_cmd never asserted, o_instr_dat=0.
- i_bus_rdy held low 5 cycles, then high -> o_bus_cmd and o_bus_addr stable all 6 REQ cycles; o_busy high throughout; completes normally.
- BUS_TIMEOUT=4, no dvalid/err after accept -> o_err_bus pulse after 4 WAIT cycles, o_instr_dat=0, o_busy low the same cycle; a later stray dvalid is ignored.
- nrst asserted during WAIT, then released, then a stray dvalid -> all outputs at reset values, state IDLE, o_instr_dat stays 0.
- UPARC_IFU_HIT_BUF_EN: fetch 0x200 (data 0x8C430000), then fetch 0x200 again -> second fetch has no o_bus_cmd, o_busy=0, data 0x8C430000 next cycle; after a 1-cycle i_flush pulse, fetch 0x200 again -> a new bus read occurs.

Source files
------------

// File: rtl/uparc_ifu_bus.sv
// Instruction fetch bus unit: one outstanding word read per fetch command, with alignment,
// bus-error and timeout reporting. Define UPARC_IFU_HIT_BUF_EN to build the one-entry hit buffer.
module uparc_ifu_bus #(
  parameter int unsigned ADDR_WIDTH  = 32,
  parameter int unsigned DATA_WIDTH  = 32,
  parameter int unsigned BUS_TIMEOUT = 255
) (
  input  logic                  clk,
  input  logic                  nrst,
  input  logic [ADDR_WIDTH-1:0] i_addr,
  input  logic                  i_rd_cmd,
  output logic [DATA_WIDTH-1:0] o_instr_dat,
  output logic                  o_busy,
  output logic                  o_err_align,
  output logic                  o_err_bus,
  input  logic                  i_flush,
  output logic [ADDR_WIDTH-1:0] o_bus_addr,
  output logic                  o_bus_cmd,
  input  logic                  i_bus_rdy,
  input  logic [DATA_WIDTH-1:0] i_bus_data,
  input  logic                  i_bus_dvalid,
  input  logic                  i_bus_err
);

  localparam int unsigned CntW = (BUS_TIMEOUT < 2) ? 1 : $clog2(BUS_TIMEOUT + 1);
  // Counter value seen in the last WAIT cycle before a forced error.
  localparam logic [CntW-1:0] TmoLast = CntW'(BUS_TIMEOUT - 1);

  typedef enum logic [1:0] {StIdle, StReq, StWait} state_e;

  state_e                state_q, state_d;
  logic [DATA_WIDTH-1:0] instr_q, instr_d;
  logic [ADDR_WIDTH-1:0] bus_addr_q, bus_addr_d;
  logic                  bus_cmd_q, bus_cmd_d;
  logic                  err_align_q, err_align_d;
  logic                  err_bus_q, err_bus_d;
  logic [CntW-1:0]       cnt_q, cnt_d;

  logic                  aligned;
  logic                  hit;
  logic [DATA_WIDTH-1:0] hit_data;
  logic                  buf_fill;
  logic                  buf_clr;
  logic                  tmo;

  assign aligned = (i_addr[1:0] == 2'b00);
  assign tmo     = (BUS_TIMEOUT != 0) && (cnt_q == TmoLast);

  always_comb begin
    state_d     = state_q;
    instr_d     = instr_q;
    bus_addr_d  = bus_addr_q;
    bus_cmd_d   = bus_cmd_q;
    err_align_d = 1'b0;
    err_bus_d   = 1'b0;
    cnt_d       = cnt_q;
    buf_fill    = 1'b0;
    buf_clr     = 1'b0;
    case (state_q)
      StIdle: begin
        if (i_rd_cmd) begin
          if (!aligned) begin
            instr_d     = '0;
            err_align_d = 1'b1;
          end else if (hit) begin
            instr_d = hit_data;
          end else begin
            bus_addr_d = i_addr;
            bus_cmd_d  = 1'b1;
            state_d    = StReq;
          end
        end
      end
      StReq: begin
        if (i_bus_rdy) begin
          bus_cmd_d = 1'b0;
          cnt_d     = '0;
          state_d   = StWait;
        end
      end
      StWait: begin
        // Error takes priority over data arriving in the same cycle.
        if (i_bus_err) begin
          instr_d   = '0;
          err_bus_d = 1'b1;
          buf_clr   = 1'b1;
          state_d   = StIdle;
        end else if (i_bus_dvalid) begin
          instr_d  = i_bus_data;
          buf_fill = 1'b1;
          state_d  = StIdle;
        end else begin
          cnt_d = (cnt_q == {CntW{1'b1}}) ? cnt_q : cnt_q + 1'b1;
          if (tmo) begin
            instr_d   = '0;
            err_bus_d = 1'b1;
            buf_clr   = 1'b1;
            state_d   = StIdle;
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state_q     <= StIdle;
      instr_q     <= '0;
      bus_addr_q  <= '0;
      bus_cmd_q   <= 1'b0;
      err_align_q <= 1'b0;
      err_bus_q   <= 1'b0;
      cnt_q       <= '0;
    end else begin
      state_q     <= state_d;
      instr_q     <= instr_d;
      bus_addr_q  <= bus_addr_d;
      bus_cmd_q   <= bus_cmd_d;
      err_align_q <= err_align_d;
      err_bus_q   <= err_bus_d;
      cnt_q       <= cnt_d;
    end
  end

`ifdef UPARC_IFU_HIT_BUF_EN
  logic                  buf_valid_q, buf_valid_d;
  logic [ADDR_WIDTH-1:0] buf_addr_q, buf_addr_d;
  logic [DATA_WIDTH-1:0] buf_data_q, buf_data_d;

  assign hit      = buf_valid_q && (buf_addr_q == i_addr);
  assign hit_data = buf_data_q;

  always_comb begin
    buf_valid_d = buf_valid_q;
    buf_addr_d  = buf_addr_q;
    buf_data_d  = buf_data_q;
    // Flush wins over a fill completing in the same cycle.
    if (i_flush || buf_clr) begin
      buf_valid_d = 1'b0;
    end else if (buf_fill) begin
      buf_valid_d = 1'b1;
      buf_addr_d  = bus_addr_q;
      buf_data_d  = i_bus_data;
    end
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      buf_valid_q <= 1'b0;
      buf_addr_q  <= '0;
      buf_data_q  <= '0;
    end else begin
      buf_valid_q <= buf_valid_d;
      buf_addr_q  <= buf_addr_d;
      buf_data_q  <= buf_data_d;
    end
  end
`else
  logic unused_buf;
  assign unused_buf = ^{i_flush, buf_fill, buf_clr};
  assign hit        = 1'b0;
  assign hit_data   = '0;
`endif

  assign o_busy      = (i_rd_cmd && aligned && !hit) || (state_q != StIdle);
  assign o_instr_dat = instr_q;
  assign o_bus_addr  = bus_addr_q;
  assign o_bus_cmd   = bus_cmd_q;
  assign o_err_align = err_align_q;
  assign o_err_bus   = err_bus_q;

endmodule

// File: tb/tb_uparc_ifu_bus.sv
// Self-checking bench for uparc_ifu_bus: directed scenarios plus randomized fetches checked
// against a transaction-level model (timeout set to 4 cycles).
module tb_uparc_ifu_bus;

  localparam int unsigned Tmo = 4;
`ifdef UPARC_IFU_HIT_BUF_EN
  localparam bit HitEn = 1'b1;
`else
  localparam bit HitEn = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        nrst;
  logic [31:0] i_addr;
  logic        i_rd_cmd;
  logic [31:0] o_instr_dat;
  logic        o_busy;
  logic        o_err_align;
  logic        o_err_bus;
  logic        i_flush;
  logic [31:0] o_bus_addr;
  logic        o_bus_cmd;
  logic        i_bus_rdy;
  logic [31:0] i_bus_data;
  logic        i_bus_dvalid;
  logic        i_bus_err;

  int total = 0;
  int bad   = 0;

  typedef struct {
    int          req_n;
    int          wait_n;
    bit          busy_cmd;
    bit          busy_ok;
    bit          addr_ok;
    bit          aerr;
    bit          berr;
    bit          busy_after;
    bit          hung;
    logic [31:0] dat;
  } obs_t;

  uparc_ifu_bus #(
    .ADDR_WIDTH (32),
    .DATA_WIDTH (32),
    .BUS_TIMEOUT(Tmo)
  ) dut (
    .clk         (clk),
    .nrst        (nrst),
    .i_addr      (i_addr),
    .i_rd_cmd    (i_rd_cmd),
    .o_instr_dat (o_instr_dat),
    .o_busy      (o_busy),
    .o_err_align (o_err_align),
    .o_err_bus   (o_err_bus),
    .i_flush     (i_flush),
    .o_bus_addr  (o_bus_addr),
    .o_bus_cmd   (o_bus_cmd),
    .i_bus_rdy   (i_bus_rdy),
    .i_bus_data  (i_bus_data),
    .i_bus_dvalid(i_bus_dvalid),
    .i_bus_err   (i_bus_err)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Acts as fetch plus bus: kind 0=data, 1=err, 2=data+err, 3=no response.
  task automatic run_fetch(input logic [31:0] addr, input int rdy_dly, input int resp_dly,
                           input int kind, input logic [31:0] data, input bit strays,
                           output obs_t o);
    bit respond;
    o.req_n = 0; o.wait_n = 0; o.busy_ok = 1; o.addr_ok = 1; o.hung = 0;
    i_addr = addr;
    i_rd_cmd = 1'b1;
    #1;
    o.busy_cmd = o_busy;
    step();
    i_rd_cmd = 1'b0;
    i_addr = $urandom;
    #1;
    o.aerr = o_err_align;
    while (o_bus_cmd === 1'b1) begin
      if (o.req_n > 30) begin o.hung = 1; break; end
      o.req_n++;
      if (o_bus_addr !== addr) o.addr_ok = 0;
      if (o_busy !== 1'b1) o.busy_ok = 0;
      i_bus_rdy = (o.req_n == rdy_dly + 1);
      i_bus_dvalid = strays && !i_bus_rdy && ($urandom_range(0, 1) == 1);
      i_bus_err = strays && !i_bus_rdy && ($urandom_range(0, 1) == 1);
      i_bus_data = $urandom;
      step();
    end
    i_bus_rdy = 1'b0; i_bus_dvalid = 1'b0; i_bus_err = 1'b0;
    if (o.req_n > 0 && !o.hung) begin
      forever begin
        if (o.wait_n > 30) begin o.hung = 1; break; end
        if (o_busy !== 1'b1) o.busy_ok = 0;
        respond = (kind != 3) && (o.wait_n == resp_dly);
        i_bus_dvalid = respond && (kind == 0 || kind == 2);
        i_bus_err = respond && (kind == 1 || kind == 2);
        i_bus_data = data;
        step();
        o.wait_n++;
        i_bus_dvalid = 1'b0; i_bus_err = 1'b0;
        #1;
        if (o_busy === 1'b0) break;
      end
    end
    o.berr = o_err_bus;
    o.dat = o_instr_dat;
    o.busy_after = o_busy;
  endtask

  task automatic test_reset();
    nrst = 1'b0; i_addr = '0; i_rd_cmd = 0; i_flush = 0;
    i_bus_rdy = 0; i_bus_data = '0; i_bus_dvalid = 0; i_bus_err = 0;
    step(); step();
    total++; if (o_instr_dat !== 32'h0) begin bad++; $display("FAIL rst_instr: got %h want 0", o_instr_dat); end
    total++; if (o_bus_addr !== 32'h0) begin bad++; $display("FAIL rst_addr: got %h want 0", o_bus_addr); end
    total++; if (o_bus_cmd !== 1'b0) begin bad++; $display("FAIL rst_cmd: got %b want 0", o_bus_cmd); end
    total++; if ({o_err_align, o_err_bus} !== 2'b00) begin bad++; $display("FAIL rst_errs: got %b want 00", {o_err_align, o_err_bus}); end
    total++; if (o_busy !== 1'b0) begin bad++; $display("FAIL rst_busy: got %b want 0", o_busy); end
    nrst = 1'b1;
    step();
  endtask

  task automatic test_min_latency();
    obs_t o;
    run_fetch(32'h100, 0, 0, 0, 32'h24020005, 1'b0, o);
    total++; if (o.busy_cmd !== 1'b1) begin bad++; $display("FAIL min_busy_cmd: got %b want 1", o.busy_cmd); end
    total++; if (o.req_n !== 1) begin bad++; $display("FAIL min_req_cycles: got %0d want 1", o.req_n); end
    total++; if (o.wait_n !== 1) begin bad++; $display("FAIL min_wait_cycles: got %0d want 1", o.wait_n); end
    total++; if (!o.addr_ok || !o.busy_ok) begin bad++; $display("FAIL min_addr_busy: got %b%b want 11", o.addr_ok, o.busy_ok); end
    total++; if (o.dat !== 32'h24020005) begin bad++; $display("FAIL min_data: got %h want 24020005", o.dat); end
    total++; if (o.busy_after !== 1'b0) begin bad++; $display("FAIL min_busy_fall: got %b want 0", o.busy_after); end
    i_bus_dvalid = 1'b1; i_bus_data = 32'hdeadbeef;
    step();
    i_bus_dvalid = 1'b0;
    total++; if (o_instr_dat !== 32'h24020005) begin bad++; $display("FAIL min_hold: got %h want 24020005", o_instr_dat); end
  endtask

  task automatic test_align();
    obs_t o;
    run_fetch(32'h102, 0, 0, 0, 32'h0, 1'b0, o);
    total++; if (o.busy_cmd !== 1'b0) begin bad++; $display("FAIL align_busy: got %b want 0", o.busy_cmd); end
    total++; if (o.req_n !== 0) begin bad++; $display("FAIL align_bus_cmd: got %0d want 0", o.req_n); end
    total++; if (o.aerr !== 1'b1) begin bad++; $display("FAIL align_pulse: got %b want 1", o.aerr); end
    total++; if (o.dat !== 32'h0) begin bad++; $display("FAIL align_data: got %h want 0", o.dat); end
    step();
    total++; if (o_err_align !== 1'b0) begin bad++; $display("FAIL align_pulse_len: got %b want 0", o_err_align); end
  endtask

  task automatic test_rdy_stall();
    obs_t o;
    run_fetch(32'h140, 5, 0, 0, 32'h3c1d0001, 1'b0, o);
    total++; if (o.req_n !== 6) begin bad++; $display("FAIL stall_req_cycles: got %0d want 6", o.req_n); end
    total++; if (!o.addr_ok || !o.busy_ok) begin bad++; $display("FAIL stall_addr_busy: got %b%b want 11", o.addr_ok, o.busy_ok); end
    total++; if (o.dat !== 32'h3c1d0001) begin bad++; $display("FAIL stall_data: got %h want 3c1d0001", o.dat); end
  endtask

  task automatic test_timeout();
    obs_t o;
    run_fetch(32'h180, 0, 0, 3, 32'h0, 1'b0, o);
    total++; if (o.wait_n !== Tmo) begin bad++; $display("FAIL tmo_wait_cycles: got %0d want %0d", o.wait_n, Tmo); end
    total++; if (o.berr !== 1'b1) begin bad++; $display("FAIL tmo_err_bus: got %b want 1", o.berr); end
    total++; if (o.dat !== 32'h0) begin bad++; $display("FAIL tmo_data: got %h want 0", o.dat); end
    total++; if (o.busy_after !== 1'b0) begin bad++; $display("FAIL tmo_busy: got %b want 0", o.busy_after); end
    i_bus_dvalid = 1'b1; i_bus_data = 32'h12345678;
    step();
    i_bus_dvalid = 1'b0;
    total++; if (o_err_bus !== 1'b0) begin bad++; $display("FAIL tmo_pulse_len: got %b want 0", o_err_bus); end
    step();
    total++; if (o_instr_dat !== 32'h0) begin bad++; $display("FAIL tmo_stray: got %h want 0", o_instr_dat); end
  endtask

  task automatic test_err_wins();
    obs_t o;
    run_fetch(32'h1c0, 1, 2, 0, 32'h0badf00d, 1'b0, o);
    total++; if (o.dat !== 32'h0badf00d) begin bad++; $display("FAIL errw_pre_data: got %h want 0badf00d", o.dat); end
    run_fetch(32'h1c4, 0, 1, 2, 32'h55aa55aa, 1'b0, o);
    total++; if (o.berr !== 1'b1 || o.dat !== 32'h0) begin bad++; $display("FAIL errw_result: got %b/%h want 1/0", o.berr, o.dat); end
  endtask

  task automatic test_reset_mid();
    obs_t o;
    run_fetch(32'h1e0, 0, 0, 0, 32'hcafe0001, 1'b0, o);
    i_addr = 32'h1e4; i_rd_cmd = 1'b1;
    step();
    i_rd_cmd = 1'b0; i_bus_rdy = 1'b1;
    step();
    i_bus_rdy = 1'b0;
    #2;
    nrst = 1'b0;
    #1;
    total++; if (o_instr_dat !== 32'h0 || o_bus_addr !== 32'h0) begin bad++; $display("FAIL rmid_async: got %h/%h want 0/0", o_instr_dat, o_bus_addr); end
    total++; if (o_busy !== 1'b0 || o_bus_cmd !== 1'b0) begin bad++; $display("FAIL rmid_busy_cmd: got %b%b want 00", o_busy, o_bus_cmd); end
    step();
    nrst = 1'b1;
    i_bus_dvalid = 1'b1; i_bus_data = 32'h77777777;
    step();
    i_bus_dvalid = 1'b0;
    step();
    total++; if (o_instr_dat !== 32'h0) begin bad++; $display("FAIL rmid_stray: got %h want 0", o_instr_dat); end
    total++; if (o_busy !== 1'b0 || o_bus_cmd !== 1'b0 || o_err_bus !== 1'b0) begin bad++; $display("FAIL rmid_idle: got %b%b%b want 000", o_busy, o_bus_cmd, o_err_bus); end
  endtask

  task automatic test_hit_buf();
    obs_t o;
    run_fetch(32'h200, 0, 0, 0, 32'h8c430000, 1'b0, o);
    run_fetch(32'h202, 0, 0, 0, 32'h0, 1'b0, o);
    i_flush = 1'b0;
    run_fetch(32'h200, 0, 0, 0, 32'h99999999, 1'b0, o);
    if (HitEn) begin
      total++; if (o.req_n !== 0 || o.busy_cmd !== 1'b0) begin bad++; $display("FAIL hit_no_bus: got %0d/%b want 0/0", o.req_n, o.busy_cmd); end
      total++; if (o.dat !== 32'h8c430000) begin bad++; $display("FAIL hit_data: got %h want 8c430000", o.dat); end
    end else begin
      total++; if (o.req_n !== 1 || o.dat !== 32'h99999999) begin bad++; $display("FAIL nohit_refetch: got %0d/%h want 1/99999999", o.req_n, o.dat); end
    end
    i_flush = 1'b1;
    step();
    i_flush = 1'b0;
    run_fetch(32'h200, 0, 0, 0, 32'h11111111, 1'b0, o);
    total++; if (o.req_n !== 1 || o.dat !== 32'h11111111) begin bad++; $display("FAIL flush_refetch: got %0d/%h want 1/11111111", o.req_n, o.dat); end
  endtask

  task automatic test_random();
    obs_t        o;
    logic [31:0] pool [4] = '{32'h1000, 32'h1004, 32'h1008, 32'h100c};
    logic [31:0] exp_dat, buf_a, buf_d, addr, data;
    bit          buf_v, aligned, hit, exp_err;
    int          rdy_dly, resp_dly, kind, exp_wait, gap;
    i_flush = 1'b1;
    step();
    i_flush = 1'b0;
    buf_v = 0; buf_a = '0; buf_d = '0;
    exp_dat = o_instr_dat;
    for (int n = 0; n < 40; n++) begin
      addr = pool[$urandom_range(0, 3)];
      if ($urandom_range(0, 3) == 0) addr[1:0] = 2'($urandom_range(1, 3));
      rdy_dly = $urandom_range(0, 3);
      resp_dly = $urandom_range(0, 5);
      kind = ($urandom_range(0, 1) == 1) ? 0 : $urandom_range(0, 3);
      data = $urandom;
      aligned = (addr[1:0] == 2'b00);
      hit = HitEn && aligned && buf_v && (buf_a == addr);
      run_fetch(addr, rdy_dly, resp_dly, kind, data, 1'b1, o);
      total++; if (o.hung) begin bad++; $display("FAIL rnd_hung[%0d]: got stuck want completion", n); end
      if (!aligned) begin
        exp_dat = '0;
        total++; if (o.aerr !== 1'b1 || o.req_n !== 0 || o.busy_cmd !== 1'b0) begin bad++; $display("FAIL rnd_align[%0d]: got %b/%0d/%b want 1/0/0", n, o.aerr, o.req_n, o.busy_cmd); end
      end else if (hit) begin
        exp_dat = buf_d;
        total++; if (o.req_n !== 0 || o.busy_cmd !== 1'b0) begin bad++; $display("FAIL rnd_hit[%0d]: got %0d/%b want 0/0", n, o.req_n, o.busy_cmd); end
      end else begin
        exp_err = (kind == 1) || (kind == 2) || (kind == 3) || (resp_dly >= Tmo);
        exp_wait = (kind != 3 && resp_dly < Tmo) ? resp_dly + 1 : Tmo;
        exp_dat = exp_err ? 32'h0 : data;
        if (exp_err) buf_v = 0;
        else begin buf_v = 1; buf_a = addr; buf_d = data; end
        total++; if (o.req_n !== rdy_dly + 1 || o.wait_n !== exp_wait) begin bad++; $display("FAIL rnd_timing[%0d]: got %0d/%0d want %0d/%0d", n, o.req_n, o.wait_n, rdy_dly + 1, exp_wait); end
        total++; if (o.berr !== exp_err || !o.addr_ok || !o.busy_ok || !o.busy_cmd) begin bad++; $display("FAIL rnd_flags[%0d]: got %b%b%b%b want %b111", n, o.berr, o.addr_ok, o.busy_ok, o.busy_cmd, exp_err); end
      end
      total++; if (o.dat !== exp_dat || o.busy_after !== 1'b0) begin bad++; $display("FAIL rnd_data[%0d]: got %h/%b want %h/0", n, o.dat, o.busy_after, exp_dat); end
      gap = $urandom_range(1, 3);
      for (int g = 0; g < gap; g++) begin
        i_bus_dvalid = ($urandom_range(0, 1) == 1);
        i_bus_err = ($urandom_range(0, 1) == 1);
        i_bus_data = $urandom;
        i_flush = ($urandom_range(0, 7) == 0);
        if (i_flush) buf_v = 0;
        step();
        i_bus_dvalid = 1'b0; i_bus_err = 1'b0; i_flush = 1'b0;
        total++; if (o_instr_dat !== exp_dat || o_busy !== 1'b0 || o_bus_cmd !== 1'b0 || o_err_bus !== 1'b0 || o_err_align !== 1'b0) begin
          bad++; $display("FAIL rnd_idle[%0d]: got %h/%b%b%b%b want %h/0000", n, o_instr_dat, o_busy, o_bus_cmd, o_err_bus, o_err_align, exp_dat);
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_min_latency();
    test_align();
    test_rdy_stall();
    test_timeout();
    test_err_wins();
    test_reset_mid();
    test_hit_buf();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
